// File: rtl/gecko_print_uart_tx.sv
// Byte-stream to UART TX (8N1, LSB first) bridge with a small FIFO that backpressures
// the print stream only when FIFO_DEPTH bytes are pending.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) on the line
//   DATA  | data bits LSB first, bit_idx selects the current bit
//   STOP  | stop bit (high); chains straight into the next START if a byte is queued
module gecko_print_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          print_in_valid,
  output logic                          print_in_ready,
  input  logic [7:0]                    print_in_payload,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr, count, count_next;
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          ready_q, tx_q, busy_q;
  logic          push, pop, empty, baud_wrap, frame_slot, going_idle;

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign baud_wrap  = (baud_cnt == BAUD_MAX);
  assign push       = print_in_valid && ready_q;
  // A new frame may start from IDLE or at the very end of a stop bit.
  assign frame_slot = (state == IDLE) || (state == STOP && baud_wrap);
  assign pop        = frame_slot && !empty;
  assign going_idle = frame_slot && empty;
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

  assign print_in_ready = ready_q;
  assign uart_tx        = tx_q;
  assign busy           = busy_q;
  assign fifo_count     = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= print_in_payload;
  end

  // Ready is computed from next-cycle occupancy, so a pop while full never frees a slot early.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + (PW+1)'(push);
      rd_ptr  <= rd_ptr + (PW+1)'(pop);
      ready_q <= (count_next != DEPTH_CNT);
      busy_q  <= !going_idle || (count_next != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr[PW-1:0]];
            tx_q  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr[PW-1:0]];
              tx_q  <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gecko_print_uart_tx.sv
// Directed bench for gecko_print_uart_tx with a line decoder and byte scoreboard.
module tb_gecko_print_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, uart_tx, busy;
  logic [2:0] fifo_count;

  gecko_print_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .print_in_valid   (valid),
    .print_in_ready   (ready),
    .print_in_payload (data),
    .uart_tx          (uart_tx),
    .busy             (busy),
    .fifo_count       (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Line decoder: samples each bit in its middle, counting from the first low sample.
  logic       dec_active = 1'b0;
  int         dec_p = 0;
  logic [7:0] dec_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         starts[$];
  int         frame_err = 0;
  int         full_ready_viol = 0;
  int         max_count = 0;

  always @(negedge clk) begin
    if (ready && fifo_count == 3'd4) full_ready_viol++;
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    if (!rst) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (uart_tx === 1'b0) begin
        dec_active = 1'b1;
        dec_p = 0;
        starts.push_back(cyc);
      end
    end else begin
      dec_p++;
      if (dec_p == 2) begin
        if (uart_tx !== 1'b0) frame_err++;
      end else if (dec_p >= 6 && dec_p <= 34 && ((dec_p - 2) % 4) == 0) begin
        dec_sh[(dec_p - 6) / 4] = uart_tx;
      end else if (dec_p == 38) begin
        if (uart_tx === 1'b1) rx_q.push_back(dec_sh);
        else frame_err++;
        dec_active = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    starts.delete();
    frame_err = 0;
    max_count = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    for (int i = 0; i < 400 && !ready; i++) @(negedge clk);
    if (!ready) check("send_ready_timeout", ready, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(output int fall_cyc);
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (!busy && !dec_active) break;
    end
    fall_cyc = cyc;
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] pend;
    logic [7:0] exp_q[$];
    int         fall, s, lows, sent;
    logic       acc;

    // 1: reset state and ready release
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", ready, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", ready, 1);

    // 2: single 0x55 frame, bit-exact timing
    clear_mon();
    fr    = {1'b1, 8'h55, 1'b0};
    data  = 8'h55;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("t2_count_after_push", fifo_count, 1);
    check("t2_busy_after_push", busy, 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check($sformatf("t2_bit_k%0d", k), uart_tx, fr[(k - 1) / 4]);
    end
    check("t2_busy_at_40", busy, 1);
    @(negedge clk);
    check("t2_busy_falls_41", busy, 0);
    check("t2_tx_idle", uart_tx, 1);

    // 3: burst 01..06 with valid held high
    clear_mon();
    for (int b = 1; b <= 6; b++) send_byte(8'(b));
    valid = 1'b0;
    wait_idle(fall);
    check("t3_nbytes", rx_q.size(), 6);
    if (rx_q.size() == 6)
      for (int i = 0; i < 6; i++) check($sformatf("t3_byte%0d", i), rx_q[i], i + 1);
    check("t3_nstarts", starts.size(), 6);
    if (starts.size() == 6) begin
      check("t3_contiguous", starts[5] - starts[0], 200);
      check("t3_total_240", fall - starts[0], 240);
    end
    check("t3_max_count", max_count, 4);
    check("t3_frame_err", frame_err, 0);

    // 4: 0x00 then 0xFF back-to-back
    clear_mon();
    send_byte(8'h00);
    send_byte(8'hFF);
    valid = 1'b0;
    wait_idle(fall);
    check("t4_nbytes", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("t4_byte0", rx_q[0], 8'h00);
      check("t4_byte1", rx_q[1], 8'hFF);
    end
    if (starts.size() == 2) check("t4_boundary_40", starts[1] - starts[0], 40);
    check("t4_frame_err", frame_err, 0);

    // 5: reset during data bit 3 of the first of three queued frames
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_byte(8'h81);
    valid = 1'b0;
    for (int i = 0; i < 100 && starts.size() == 0; i++) @(negedge clk);
    check("t5_frame_started", starts.size(), 1);
    s = (starts.size() > 0) ? starts[0] : cyc;
    for (int i = 0; i < 100 && cyc < s + 17; i++) @(negedge clk);
    check("t5_pre_bit3_low", uart_tx, 0);
    rst = 1'b0;
    #1;
    check("t5_tx_high_now", uart_tx, 1);
    check("t5_count_zero", fifo_count, 0);
    check("t5_busy_zero", busy, 0);
    check("t5_ready_zero", ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_mon();
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("t5_line_quiet", lows, 0);
    check("t5_no_frames", starts.size(), 0);
    check("t5_count_after", fifo_count, 0);
    check("t5_busy_after", busy, 0);

    // 6: random valid toggling, 200 bytes, scoreboard
    clear_mon();
    full_ready_viol = 0;
    sent = 0;
    pend = 8'($urandom_range(0, 255));
    for (int it = 0; it < 40000 && sent < 200; it++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) != 0);
      data  = pend;
      acc   = valid && ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(pend);
        sent++;
        pend = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    valid = 1'b0;
    check("t6_sent", sent, 200);
    wait_idle(fall);
    check("t6_nbytes", rx_q.size(), exp_q.size());
    if (rx_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) check($sformatf("t6_byte%0d", i), rx_q[i], exp_q[i]);
    check("t6_ready_while_full", full_ready_viol, 0);
    check("t6_max_count", max_count, 4);
    check("t6_frame_err", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
